// File: rtl/signal_system_pkg.sv
// -----------------------------------------------------------------------------
// signal_system_pkg
//   Shared definitions for the highway/country-road crossing controller.
//   - state_t      : 2-bit state encoding. All four codes are legal states.
//   - LIGHT_GREEN  : light control value for "green"
//   - LIGHT_OFF    : light control value for "not green"
//   - go_request   : the combined condition that starts and confirms a
//                    hand-over of right-of-way to the country road.
// -----------------------------------------------------------------------------
package signal_system_pkg;

   typedef enum logic [1:0] {
      HGD = 2'b00,   // highway green, resting state
      CGT = 2'b01,   // moving toward country green
      CG  = 2'b11,   // country green
      HGT = 2'b10    // moving back to highway green
   } state_t;

   localparam logic LIGHT_GREEN = 1'b1;
   localparam logic LIGHT_OFF   = 1'b0;

   // The hand-over needs the west and east conditions and a waiting country car.
   function automatic logic go_request(input logic w, input logic e, input logic c);
      return w & e & c;
   endfunction

endpackage

// File: rtl/signal_system.sv
// -----------------------------------------------------------------------------
// signal_system
//   Moore traffic-light controller for a highway/country-road crossing.
//
//   Ports:
//     CLK   in   system clock, all state updates on the rising edge
//     RST   in   synchronous active-high reset, forces HGD
//     W     in   west-side request/condition
//     E     in   east-side request/condition
//     C     in   country-road car present
//     HL    out  highway light (1 = green)
//     CL    out  country light (1 = green)
//     STATE out  current state register, exposed for debug
//
//   Sequence: HGD -(go)-> CGT -(go)-> CG -(!C)-> HGT -> HGD.
//   CGT falls back to HGD if go drops before confirmation. Outputs decode
//   only the state register, so inputs never reach the lights combinationally.
// -----------------------------------------------------------------------------
module signal_system
   import signal_system_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       W,
   input  logic       E,
   input  logic       C,
   output logic       HL,
   output logic       CL,
   output logic [1:0] STATE
);

   state_t state_q;
   state_t state_d;
   logic   go;

   assign go = go_request(W, E, C);

   // State register; reset wins over any transition.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= HGD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HGD: state_d = go ? CGT : HGD;
         // A request withdrawn mid-transition aborts back to highway green.
         CGT: state_d = go ? CG : HGD;
         // Only the country car matters once the country road is green.
         CG:  state_d = C ? CG : HGT;
         HGT: state_d = HGD;
         default: state_d = HGD;
      endcase
   end

   // Moore output decode; the two lights are never green together.
   always_comb begin
      HL = LIGHT_OFF;
      CL = LIGHT_OFF;
      case (state_q)
         HGD: HL = LIGHT_GREEN;
         CG:  CL = LIGHT_GREEN;
         default: begin
            HL = LIGHT_OFF;
            CL = LIGHT_OFF;
         end
      endcase
   end

   assign STATE = state_q;

endmodule

// File: tb/tb_signal_system.sv
// -----------------------------------------------------------------------------
// tb_signal_system
//   Directed scenarios followed by randomized traffic, checked against a
//   road-level reference model of the crossing.
// -----------------------------------------------------------------------------
module tb_signal_system;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       W = 1'b0;
   logic       E = 1'b0;
   logic       C = 1'b0;
   logic       HL;
   logic       CL;
   logic [1:0] STATE;

   int         n_checks = 0;
   int         n_fails  = 0;
   logic [3:0] exp_q[$];

   // Reference model: which stage of the right-of-way hand-over we are in.
   //   0 = highway has right of way
   //   1 = country car waiting, hand-over requested
   //   2 = country road has right of way
   //   3 = handing right of way back to the highway
   int         phase = 0;

   signal_system dut (
      .CLK   (CLK),
      .RST   (RST),
      .W     (W),
      .E     (E),
      .C     (C),
      .HL    (HL),
      .CL    (CL),
      .STATE (STATE)
   );

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   function automatic int model_next(input int ph, input bit r, input bit w,
                                     input bit e, input bit c);
      bit go;
      go = w && e && c;
      if (r) return 0;
      case (ph)
         0: return go ? 1 : 0;
         1: return go ? 2 : 0;
         2: return c ? 2 : 3;
         default: return 0;
      endcase
   endfunction

   // Expected {STATE, HL, CL} for each stage, as listed in the state table.
   function automatic logic [3:0] model_out(input int ph);
      case (ph)
         0: return 4'b00_1_0;
         1: return 4'b01_0_0;
         2: return 4'b11_0_1;
         default: return 4'b10_0_0;
      endcase
   endfunction

   // ---------------- driver + scoreboard ----------------
   task automatic step(input bit r, input bit w, input bit e, input bit c,
                       input string tag);
      logic [3:0] exp_v;
      logic [3:0] obs_v;
      RST = r;
      W   = w;
      E   = e;
      C   = c;
      @(posedge CLK);
      phase = model_next(phase, r, w, e, c);
      exp_q.push_back(model_out(phase));
      #1;
      obs_v = {STATE, HL, CL};
      exp_v = exp_q.pop_front();
      n_checks++;
      assert (obs_v === exp_v) else begin
         n_fails++;
         $error("FAIL %s: observed STATE=%b HL=%b CL=%b, expected STATE=%b HL=%b CL=%b",
                tag, obs_v[3:2], obs_v[1], obs_v[0], exp_v[3:2], exp_v[1], exp_v[0]);
      end
      n_checks++;
      assert ((HL & CL) !== 1'b1) else begin
         n_fails++;
         $error("FAIL %s_exclusive: observed HL=%b CL=%b, expected not both green",
                tag, HL, CL);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (2) @(posedge CLK);
      #1;

      // Reset with go asserted, then hold reset.
      step(1, 1, 1, 1, "reset");
      for (int i = 0; i < 3; i++) step(1, 1, 1, 1, "reset_hold");

      // Partial requests leave the highway green.
      step(0, 1, 1, 0, "hgd_hold_110");
      step(0, 0, 1, 1, "hgd_hold_011");
      step(0, 1, 0, 1, "hgd_hold_101");

      // Abort from the transition state.
      step(0, 1, 1, 1, "abort_to_cgt");
      step(0, 1, 0, 1, "abort_to_hgd");

      // Full cycle.
      step(0, 1, 1, 1, "full_cgt");
      step(0, 1, 1, 1, "full_cg");
      step(0, 1, 1, 1, "full_cg_hold");
      step(0, 1, 1, 0, "full_hgt");
      step(0, 0, 0, 0, "full_hgd");

      // Country green ignores W/E.
      step(0, 1, 1, 1, "cg_entry_cgt");
      step(0, 1, 1, 1, "cg_entry_cg");
      step(0, 0, 0, 1, "cg_ignore_we_1");
      step(0, 0, 0, 1, "cg_ignore_we_2");
      step(0, 0, 0, 0, "cg_exit_hgt");
      step(0, 1, 1, 1, "hgt_ignores_go");

      // Reset while country green.
      step(0, 1, 1, 1, "mid_cgt");
      step(0, 1, 1, 1, "mid_cg");
      step(1, 0, 0, 1, "mid_reset");

      // Randomized traffic, biased toward go so that all stages are visited.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 24) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0),
              "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
